// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0040_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        HOLD,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] pc_plus_4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    // Instructions are word aligned; low address bits of a redirect are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage signal bundle: control from ID/EX, imem handshake and IF->ID packet.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic            stall_in;
    logic            redirect_in;
    logic [XLEN-1:0] redirect_pc_in;
    logic            imem_req_out;
    logic [XLEN-1:0] imem_addr_out;
    logic            imem_ack_in;
    logic [XLEN-1:0] imem_rdata_in;
    logic [XLEN-1:0] instruction_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus_4_out;
    logic            valid_out;

    modport master (
        input  stall_in, redirect_in, redirect_pc_in, imem_ack_in, imem_rdata_in,
        output imem_req_out, imem_addr_out, instruction_out, pc_out, pc_plus_4_out, valid_out
    );

    modport slave (
        output stall_in, redirect_in, redirect_pc_in, imem_ack_in, imem_rdata_in,
        input  imem_req_out, imem_addr_out, instruction_out, pc_out, pc_plus_4_out, valid_out
    );

endinterface

// File: rtl/instruction_fetch_unit_hold_buffer.sv
// One-entry buffer for a fetched word that arrived while decode was stalled.
module instruction_fetch_unit_hold_buffer
    import instruction_fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  fetch_pkt_t wr_data,
    input  logic       rd_clr,
    input  logic       flush,
    output fetch_pkt_t rd_data,
    output logic       full
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
            full    <= 1'b0;
        end else if (flush || rd_clr) begin
            full    <= 1'b0;
        end else if (wr_en) begin
            rd_data <= wr_data;
            full    <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the imem req/ack handshake and
// produces IF->ID packets, honouring stall and redirect.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;

    logic            req_d;
    logic [XLEN-1:0] addr_d;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] pc_out_d;
    logic [XLEN-1:0] pc_plus_4_d;
    logic            valid_d;

    logic            hb_wr;
    logic            hb_clr;
    logic            hb_flush;
    fetch_pkt_t      hb_wr_data;
    fetch_pkt_t      hb_rd_data;
    logic            hb_full;

    logic            out_free;
    logic [XLEN-1:0] redirect_pc;

    assign out_free    = !bus.valid_out || !bus.stall_in;
    assign redirect_pc = align_pc(bus.redirect_pc_in);
    assign hb_wr_data  = '{instr: bus.imem_rdata_in, pc: pc_q};

    instruction_fetch_unit_hold_buffer u_hold_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (hb_wr),
        .wr_data (hb_wr_data),
        .rd_clr  (hb_clr),
        .flush   (hb_flush),
        .rd_data (hb_rd_data),
        .full    (hb_full)
    );

    // Next-state, next-PC and next-output computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        instr_d     = bus.instruction_out;
        pc_out_d    = bus.pc_out;
        pc_plus_4_d = bus.pc_plus_4_out;
        valid_d     = bus.valid_out;
        hb_wr       = 1'b0;
        hb_clr      = 1'b0;
        hb_flush    = 1'b0;

        // A consumed packet with nothing to replace it becomes a bubble.
        if (out_free) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        unique case (state_q)
            BOOT: begin
                state_d = REQ;
                if (bus.redirect_in) pc_d = redirect_pc;
            end
            REQ: begin
                if (bus.redirect_in) begin
                    pc_d = redirect_pc;
                    if (!bus.imem_ack_in) begin
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (bus.imem_ack_in) begin
                    pc_d = pc_plus_4(pc_q);
                    if (out_free) begin
                        instr_d     = bus.imem_rdata_in;
                        pc_out_d    = pc_q;
                        pc_plus_4_d = pc_plus_4(pc_q);
                        valid_d     = 1'b1;
                    end else begin
                        hb_wr   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_in) begin
                    hb_flush = 1'b1;
                    pc_d     = redirect_pc;
                    state_d  = REQ;
                end else if (!bus.stall_in && hb_full) begin
                    instr_d     = hb_rd_data.instr;
                    pc_out_d    = hb_rd_data.pc;
                    pc_plus_4_d = pc_plus_4(hb_rd_data.pc);
                    valid_d     = 1'b1;
                    hb_clr      = 1'b1;
                    state_d     = REQ;
                end
            end
            DROP: begin
                if (bus.redirect_in) pc_d = redirect_pc;
                if (bus.imem_ack_in) state_d = REQ;
            end
        endcase

        // Redirect flushes the presented packet regardless of stall or ack.
        if (bus.redirect_in) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        req_d  = (state_d == REQ) || (state_d == DROP);
        addr_d = (state_d == DROP) ? drop_addr_d : pc_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= BOOT;
            pc_q                <= RESET_PC;
            drop_addr_q         <= RESET_PC;
            bus.imem_req_out    <= 1'b0;
            bus.imem_addr_out   <= RESET_PC;
            bus.instruction_out <= NOP_INSTR;
            bus.pc_out          <= '0;
            bus.pc_plus_4_out   <= '0;
            bus.valid_out       <= 1'b0;
        end else begin
            state_q             <= state_d;
            pc_q                <= pc_d;
            drop_addr_q         <= drop_addr_d;
            bus.imem_req_out    <= req_d;
            bus.imem_addr_out   <= addr_d;
            bus.instruction_out <= instr_d;
            bus.pc_out          <= pc_out_d;
            bus.pc_plus_4_out   <= pc_plus_4_d;
            bus.valid_out       <= valid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// stall/redirect/ack traffic, all compared against a transaction-level model.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam logic [31:0] KEY  = 32'hA5A5_A5A5;
    localparam logic [31:0] RPC  = 32'h0040_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Reference model: fetch pointer, pending-drop marker, queue of parked words.
    bit          m_boot;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_drop_addr;
    logic [63:0] m_held[$];
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pco;
    logic [31:0] m_pc4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_boot  = 1'b1;
        m_drop  = 1'b0;
        m_pc    = RPC;
        m_drop_addr = RPC;
        m_held.delete();
        m_valid = 1'b0;
        m_instr = NOP;
        m_pco   = '0;
        m_pc4   = '0;
    endfunction

    function automatic void present(input logic [31:0] instr, input logic [31:0] pc);
        m_valid = 1'b1;
        m_instr = instr;
        m_pco   = pc;
        m_pc4   = pc + 32'd4;
    endfunction

    function automatic void bubble();
        m_valid = 1'b0;
        m_instr = NOP;
    endfunction

    function automatic bit model_req();
        return !m_boot && (m_held.size() == 0);
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, 32'(bus.valid_out), 32'(m_valid));
        check({tag, ".instr"}, bus.instruction_out, m_instr);
        check({tag, ".pc"}, bus.pc_out, m_pco);
        check({tag, ".pc4"}, bus.pc_plus_4_out, m_pc4);
        check({tag, ".req"}, 32'(bus.imem_req_out), 32'(model_req()));
        if (model_req())
            check({tag, ".addr"}, bus.imem_addr_out, m_drop ? m_drop_addr : m_pc);
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit ak,
                        input string tag);
        bit          req_now;
        bit          ack_eff;
        bit          free;
        logic [31:0] tgt;
        logic [31:0] exp_data;
        req_now  = model_req();
        ack_eff  = ak && (req_now || m_boot);
        exp_data = (m_drop ? m_drop_addr : m_pc) ^ KEY;
        tgt      = rpc & 32'hFFFF_FFFC;
        free     = !m_valid || !st;
        bus.stall_in       = st;
        bus.redirect_in    = rd;
        bus.redirect_pc_in = rpc;
        bus.imem_ack_in    = ack_eff;
        bus.imem_rdata_in  = bus.imem_addr_out ^ KEY;
        @(posedge clk);
        if (m_boot) begin
            m_boot = 1'b0;
            if (rd) m_pc = tgt;
        end else if (rd) begin
            if (req_now && !ack_eff && !m_drop) begin
                m_drop      = 1'b1;
                m_drop_addr = m_pc;
            end else if (m_drop && ack_eff) begin
                m_drop = 1'b0;
            end
            m_held.delete();
            m_pc = tgt;
            bubble();
        end else if (m_held.size() != 0) begin
            if (!st) begin
                present(m_held[0][63:32], m_held[0][31:0]);
                void'(m_held.pop_front());
            end
        end else if (m_drop) begin
            if (ack_eff) m_drop = 1'b0;
            if (free) bubble();
        end else if (ack_eff) begin
            if (free) present(exp_data, m_pc);
            else m_held.push_back({exp_data, m_pc});
            m_pc = m_pc + 32'd4;
        end else if (free) begin
            bubble();
        end
        #1;
        compare_all(tag);
    endtask

    logic [31:0] frozen;
    logic [31:0] old_addr;

    initial begin
        bus.stall_in       = 1'b0;
        bus.redirect_in    = 1'b0;
        bus.redirect_pc_in = '0;
        bus.imem_ack_in    = 1'b0;
        bus.imem_rdata_in  = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        reset = 1'b1;

        // Streaming with ack every cycle: first packet on the second edge.
        step(0, 0, '0, 1, "t1_boot");
        step(0, 0, '0, 1, "t1_first");
        check("t1_first_pc", bus.pc_out, 32'h0040_0000);
        check("t1_first_pc4", bus.pc_plus_4_out, 32'h0040_0004);
        for (int i = 1; i < 5; i++) begin
            step(0, 0, '0, 1, "t1_stream");
            check("t1_inc", bus.pc_out, 32'h0040_0000 + 32'(4 * i));
        end

        // Three stalled cycles park one word; release resumes with no skip.
        frozen = bus.pc_out;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, '0, 1, "t2_stall");
            check("t2_frozen", bus.pc_out, frozen);
        end
        step(0, 0, '0, 1, "t2_release");
        check("t2_next", bus.pc_out, frozen + 32'd4);
        step(0, 0, '0, 1, "t2_after");
        check("t2_next2", bus.pc_out, frozen + 32'd8);

        // Redirect coinciding with ack: flush, misaligned target gets aligned.
        step(0, 1, 32'h0040_0103, 1, "t3_redir");
        check("t3_nop", bus.instruction_out, NOP);
        check("t3_addr", bus.imem_addr_out, 32'h0040_0100);
        step(0, 0, '0, 1, "t3_fetch");
        check("t3_pc", bus.pc_out, 32'h0040_0100);

        // Redirect with request outstanding: old address held until ack.
        old_addr = bus.imem_addr_out;
        step(0, 1, 32'h0040_0200, 0, "t4_redir");
        for (int i = 0; i < 2; i++) begin
            step(0, 0, '0, 0, "t4_wait");
            check("t4_hold_addr", bus.imem_addr_out, old_addr);
        end
        step(0, 0, '0, 1, "t4_drop_ack");
        check("t4_no_valid", 32'(bus.valid_out), 32'd0);
        check("t4_new_addr", bus.imem_addr_out, 32'h0040_0200);
        step(0, 0, '0, 1, "t4_fetch");
        check("t4_pc", bus.pc_out, 32'h0040_0200);

        // Redirect while a word is parked and decode is stalled.
        step(1, 0, '0, 1, "t5_park");
        step(1, 1, 32'h0040_0300, 0, "t5_redir");
        check("t5_flush", 32'(bus.valid_out), 32'd0);
        step(0, 0, '0, 1, "t5_fetch");
        check("t5_pc", bus.pc_out, 32'h0040_0300);

        // Address wrap at the top of the space.
        step(0, 1, 32'hFFFF_FFFC, 1, "t6_redir");
        step(0, 0, '0, 1, "t6_top");
        check("t6_pc4_wrap", bus.pc_plus_4_out, 32'h0000_0000);
        step(0, 0, '0, 1, "t6_wrap");
        check("t6_pc_wrap", bus.pc_out, 32'h0000_0000);

        // Asynchronous reset while dropping; a stale ack after release is ignored.
        step(0, 1, 32'h0040_0400, 0, "t6_drop");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("t6_async_rst");
        bus.imem_ack_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 0, '0, 1, "t6_stale_ack");
        step(0, 0, '0, 1, "t6_restart");
        check("t6_restart_pc", bus.pc_out, RPC);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0,
                 $urandom,
                 $urandom_range(0, 9) < 6,
                 "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Instruction Fetch stage: owns the PC and runs a req/ack handshake to instruction memory.
- Presents {instruction, pc, pc+4, valid} packets to the IF->ID pipeline register. It is the producer end of that interface.
- Honours stall from hazard detection and redirect (branch/jump flush) from EX.
- A one-entry hold buffer absorbs a fetch that returns while decode is stalled.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, addi x0,x0,0; driven as bubble instruction.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- stall_in  input  1  decode cannot accept the presented packet this cycle.
- redirect_in  input  1  flush and restart fetch at redirect_pc_in.
- redirect_pc_in  input  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req_out  output  1  memory request valid.
- imem_addr_out  output  32  request address; equals the internal PC (or the drop address in DROP).
- imem_ack_in  input  1  memory returns imem_rdata_in this cycle.
- imem_rdata_in  input  32  fetched instruction word.
- instruction_out  output  32  presented instruction.
- pc_out  output  32  PC of the presented instruction.
- pc_plus_4_out  output  32  pc_out + 4, modulo 2^32.
- valid_out  output  1  presented packet is real (0 = bubble).

Behaviour:
- Reset (reset==0, async):
  - pc = RESET_PC, state = BOOT, hold buffer empty.
  - instruction_out = NOP_INSTR; pc_out = 0; pc_plus_4_out = 0; valid_out = 0; imem_req_out = 0.
- Consumption: a packet is consumed on any rising edge with valid_out=1 and stall_in=0.
  - Output regs may load when valid_out==0 or stall_in==0.
  - Otherwise output regs hold all fields unchanged.
- States:
  - BOOT: imem_req_out=0. Next edge: REQ. If redirect_in, pc <= redirect target.
  - REQ: imem_req_out=1, imem_addr_out=pc. Address is stable until ack. On edge with:
    - redirect_in & ack: discard data; pc <= target; stay REQ.
    - redirect_in & !ack: latch drop flag; pc <= target; go DROP.
    - ack & output free: load outputs {rdata, pc, pc+4, 1}; pc <= pc+4; stay REQ.
    - ack & output blocked: write hold buffer {rdata, pc}; pc <= pc+4; go HOLD.
    - no ack: stay REQ.
  - HOLD: imem_req_out=0.
    - stall_in=0: outputs <= hold buffer; buffer empty; go REQ.
    - redirect_in: buffer discarded; pc <= target; go REQ.
  - DROP: imem_req_out=1 with the old address held in a separate register.
    - On ack: discard data; go REQ at the already-updated pc.
    - A further redirect in DROP updates pc only.
- Redirect priority: redirect beats stall and ack.
  - On any redirect edge, valid_out <= 0 and instruction_out <= NOP_INSTR (flush).
  - pc_out and pc_plus_4_out hold their values.
- Latency:
  - With ack in the same cycle as req, first valid packet appears 2 edges after reset release (BOOT, REQ).
  - Steady state is 1 packet/cycle.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No misalignment trap.
- Reset mid-request: the outstanding ack after reset release is ignored. Memory must drop the request when req deasserts.

Decomposition:
- fetch_pkg: state enum {BOOT, REQ, HOLD, DROP}, NOP_INSTR, RESET_PC default, packet struct {instr, pc}.
- Sub-module fetch_hold_buffer: 1-entry register with write, read/clear and flush, plus a full flag.

Test Plan:
1. Release reset, ack tied 1, rdata = addr ^ 32'hA5A5_A5A5.
   - Expect valid_out=1 at edge 2 with pc_out=32'h0040_0000 and pc_plus_4_out=32'h0040_0004.
   - Then pc_out increments by 4 every cycle.
2. stall_in=1 for 3 cycles mid-stream, ack=1.
   - Expect outputs frozen.
   - Exactly one word in hold buffer; imem_req_out=0 for 2 cycles.
   - On release, next pc_out = frozen+4 with no skip or duplicate.
3. redirect_in=1, redirect_pc_in=32'h0040_0103 while ack=1.
   - Next edge: valid_out=0 and instruction_out=32'h0000_0013.
   - Next fetch address = 32'h0040_0100.
4. Redirect to 32'h0040_0200 while req pending and ack=0 for 3 cycles.
   - Expect imem_addr_out held at the old address until ack.
   - That data is never presented.
   - Then a request at 32'h0040_0200.
5. Redirect while in HOLD with stall_in=1.
   - Held word discarded; valid_out=0.
   - Next packet pc_out = redirect target.
6. Redirect to 32'hFFFF_FFFC.
   - First packet pc_plus_4_out=0, next pc_out=0.
   - Assert reset mid-DROP: outputs return to reset values asynchronously.
